// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch unit
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int INSTR_W = 32;
  localparam int PC_INC  = 4;

  // Counters must hold the value DEPTH itself, hence one bit more than the pointers.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - memory, decode and redirect signals of the fetch unit
interface instr_fetch_if
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  instr_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - synchronous FIFO with flush, used for prefetch words and PC tags
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch: PC generation, credit-limited requests, prefetch FIFO, redirect
// Define IFETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst,
  instr_fetch_if.master  bus
);

  localparam int CW = cnt_w(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic              hold_q, hold_d;

  logic                      redir;
  logic [ADDR_W-1:0]         redir_pc;
  logic                      credit_ok, req_valid, req_fire;
  logic                      rsp_dec, rsp_live, bypass;
  logic                      data_push, data_pop, data_full, data_empty;
  logic [CW-1:0]             data_count;
  logic [INSTR_W+ADDR_W-1:0] data_head;
  logic                      tag_push, tag_full, tag_empty;
  logic [ADDR_W-1:0]         tag_head;
  logic [CW-1:0]             tag_count;
  logic                      unused_tag_count;

  assign redir    = bus.redirect_valid;
  assign redir_pc = {bus.redirect_pc[ADDR_W-1:2], 2'b00};

  // Every request in flight owns a FIFO slot, so responses can never be refused.
  assign credit_ok = ({1'b0, data_count} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);
  assign req_valid = (state_q == RUN) && !hold_q && credit_ok;
  assign req_fire  = req_valid && bus.imem_req_ready;

  assign rsp_dec  = bus.imem_rsp_valid && (outstanding_q != '0);
  // A response arriving with a redirect belongs to the abandoned path.
  assign rsp_live = bus.imem_rsp_valid && (discard_q == '0) && !redir && !tag_empty;

`ifdef IFETCH_BYPASS_EN
  assign bypass = rsp_live && data_empty && bus.instr_ready;
`else
  assign bypass = 1'b0;
`endif

  assign data_pop  = !data_empty && bus.instr_ready;
  assign data_push = rsp_live && !bypass && (!data_full || data_pop);
  assign tag_push  = req_fire && !tag_full;

  ifetch_fifo #(.W(INSTR_W + ADDR_W), .DEPTH(DEPTH)) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (data_push),
    .push_data ({bus.imem_rsp_data, tag_head}),
    .pop       (data_pop),
    .flush     (redir),
    .head      (data_head),
    .count     (data_count),
    .full      (data_full),
    .empty     (data_empty)
  );

  ifetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tag_push),
    .push_data (fetch_pc_q),
    .pop       (rsp_live),
    .flush     (redir),
    .head      (tag_head),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  assign unused_tag_count = ^tag_count;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_dec);
    discard_d     = discard_q - CW'(bus.imem_rsp_valid && (discard_q != '0));
    hold_d        = 1'b0;
    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
    end
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     state_d = RUN;
      DRAIN:   if (discard_d == '0) state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (redir) begin
      fetch_pc_d = redir_pc;
      hold_d     = 1'b1;
      // In DRAIN everything still in flight is already counted as stale.
      if (state_q != DRAIN) begin
        discard_d = outstanding_d;
      end
      state_d = (discard_d != '0) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      hold_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      hold_q        <= hold_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = !data_empty || bypass;

  always_comb begin
    bus.instruction = '0;
    bus.instr_pc    = '0;
    if (!data_empty) begin
      bus.instruction = data_head[INSTR_W+ADDR_W-1:ADDR_W];
      bus.instr_pc    = data_head[ADDR_W-1:0];
    end else if (bypass) begin
      bus.instruction = bus.imem_rsp_data;
      bus.instr_pc    = tag_head;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch against a program-order model
module tb_instr_fetch;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(32)) bus ();

  instr_fetch #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          lat_min = 1, lat_max = 1, rdy_pct = 100, mrdy_pct = 100;
  logic [31:0] exp_pc, exp_req_pc;
  bit          stall_prev, post_redir, arm_collide, collided;
  logic [31:0] hold_instr, hold_pc;
  int          stale_left, expect_req_at, reqs_issued;
  int          first_rsp_cyc, first_valid_cyc;
  logic [31:0] acc_pc[$];
  logic [31:0] acc_instr[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic clear_model();
    mq_addr.delete();
    mq_due.delete();
    exp_pc        = 32'h0;
    exp_req_pc    = 32'h0;
    stall_prev    = 1'b0;
    post_redir    = 1'b0;
    arm_collide   = 1'b0;
    stale_left    = 0;
    expect_req_at = -1;
  endtask

  // One clock of memory model, decode model and program-order scoreboard.
  task automatic step(input bit want_redir, input logic [31:0] tgt);
    bit do_redir;
    int lat;
    @(posedge clk);
    cyc++;
    #1;
    if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = word_of(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
      if (stale_left > 0) begin
        stale_left--;
        if (stale_left == 0) expect_req_at = cyc + 1;
      end
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    bus.imem_req_ready = ($urandom_range(99) < mrdy_pct);
    bus.instr_ready    = ($urandom_range(99) < rdy_pct);
    do_redir = want_redir;
    if (arm_collide && bus.imem_rsp_valid && bus.imem_req_valid && bus.imem_req_ready) begin
      do_redir    = 1'b1;
      arm_collide = 1'b0;
      collided    = 1'b1;
    end
    bus.redirect_valid = do_redir;
    bus.redirect_pc    = do_redir ? tgt : $urandom;
    #1;
    if (post_redir) begin
      tests_run++;
      if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL post_redirect: cyc=%0d instr_valid=%b req_valid=%b, want 0 0", cyc, bus.instr_valid, bus.imem_req_valid);
      end
    end
    if (stall_prev) begin
      tests_run++;
      if (bus.instr_valid !== 1'b1 || bus.instruction !== hold_instr || bus.instr_pc !== hold_pc) begin
        tests_failed++;
        $display("FAIL stall_hold: cyc=%0d got v=%b %h@%h, want v=1 %h@%h", cyc, bus.instr_valid, bus.instruction, bus.instr_pc, hold_instr, hold_pc);
      end
    end
    if (stale_left > 0) begin
      tests_run++;
      if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL drain_quiet: cyc=%0d req_valid=%b instr_valid=%b, want 0 0", cyc, bus.imem_req_valid, bus.instr_valid);
      end
    end
    if (cyc == expect_req_at) begin
      tests_run++;
      if (bus.imem_req_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL resume_req: cyc=%0d req_valid=%b, want 1", cyc, bus.imem_req_valid);
      end
    end
    if (bus.instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.instr_valid === 1'b1 && bus.instr_ready) begin
      tests_run++;
      if (bus.instr_pc !== exp_pc || bus.instruction !== word_of(exp_pc)) begin
        tests_failed++;
        $display("FAIL instr_seq: cyc=%0d got %h@%h, want %h@%h", cyc, bus.instruction, bus.instr_pc, word_of(exp_pc), exp_pc);
      end
      acc_pc.push_back(bus.instr_pc);
      acc_instr.push_back(bus.instruction);
      exp_pc += 32'd4;
    end
    if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready) begin
      tests_run++;
      if (bus.imem_req_addr !== exp_req_pc) begin
        tests_failed++;
        $display("FAIL req_addr: cyc=%0d got %h, want %h", cyc, bus.imem_req_addr, exp_req_pc);
      end
      exp_req_pc += 32'd4;
      lat = $urandom_range(lat_max, lat_min);
      mq_addr.push_back(bus.imem_req_addr);
      mq_due.push_back(cyc + lat);
      reqs_issued++;
    end
    tests_run++;
    if (mq_addr.size() > DEPTH) begin
      tests_failed++;
      $display("FAIL credit: cyc=%0d in_flight=%0d, want <= %0d", cyc, mq_addr.size(), DEPTH);
    end
    stall_prev = bus.instr_valid && !bus.instr_ready && !do_redir;
    hold_instr = bus.instruction;
    hold_pc    = bus.instr_pc;
    post_redir = do_redir;
    if (do_redir) begin
      exp_pc        = tgt & 32'hFFFF_FFFC;
      exp_req_pc    = tgt & 32'hFFFF_FFFC;
      stale_left    = mq_addr.size();
      expect_req_at = (stale_left == 0) ? cyc + 2 : -1;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst                = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    clear_model();
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic run_until_acc(input int n, input int budget, input string name);
    int k = 0;
    while (acc_pc.size() < n && k < budget) begin
      step(1'b0, 32'h0);
      k++;
    end
    tests_run++;
    if (acc_pc.size() < n) begin
      tests_failed++;
      $display("FAIL %s_timeout: got %0d instructions, want %0d", name, acc_pc.size(), n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run += 4;
    if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    if (bus.instr_valid !== 1'b0)    begin tests_failed++; $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); end
    if (bus.instruction !== 32'h0)   begin tests_failed++; $display("FAIL reset_instruction: got %h want 0", bus.instruction); end
    if (bus.instr_pc !== 32'h0)      begin tests_failed++; $display("FAIL reset_instr_pc: got %h want 0", bus.instr_pc); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int want_lat;
    lat_min = 1; lat_max = 1; rdy_pct = 100; mrdy_pct = 100;
    first_rsp_cyc = -1; first_valid_cyc = -1;
    acc_pc.delete(); acc_instr.delete();
    run_until_acc(4, 40, "basic");
    if (acc_pc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (acc_pc[i] !== 32'(4 * i)) begin
          tests_failed++;
          $display("FAIL basic_pc%0d: got %h want %h", i, acc_pc[i], 32'(4 * i));
        end
      end
      tests_run++;
      if (acc_instr[1] !== 32'hA5A5_0004) begin
        tests_failed++;
        $display("FAIL basic_word4: got %h want a5a50004", acc_instr[1]);
      end
    end
`ifdef IFETCH_BYPASS_EN
    want_lat = 0;
`else
    want_lat = 1;
`endif
    tests_run++;
    if (first_valid_cyc - first_rsp_cyc !== want_lat) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d cycles want %0d", first_valid_cyc - first_rsp_cyc, want_lat);
    end
  endtask

  task automatic test_backpressure();
    int n0;
    rdy_pct = 0;
    reqs_issued = 0;
    repeat (10) step(1'b0, 32'h0);
    tests_run += 3;
    if (reqs_issued > DEPTH) begin tests_failed++; $display("FAIL bp_requests: got %0d want <= %0d", reqs_issued, DEPTH); end
    if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_req_valid: got %b want 0", bus.imem_req_valid); end
    if (bus.instr_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_instr_valid: got %b want 1", bus.instr_valid); end
    rdy_pct = 100;
    n0 = acc_pc.size();
    repeat (4) step(1'b0, 32'h0);
    tests_run++;
    if (acc_pc.size() - n0 !== 4) begin
      tests_failed++;
      $display("FAIL bp_no_gap: got %0d accepts in 4 cycles want 4", acc_pc.size() - n0);
    end
  endtask

  task automatic test_redirect();
    lat_min = 3; lat_max = 3; rdy_pct = 100; mrdy_pct = 100;
    repeat (8) step(1'b0, 32'h0);
    acc_pc.delete(); acc_instr.delete();
    step(1'b1, 32'h0000_0103);
    run_until_acc(1, 30, "redirect");
    if (acc_pc.size() >= 1) begin
      tests_run++;
      if (acc_pc[0] !== 32'h0000_0100) begin
        tests_failed++;
        $display("FAIL redirect_target: got %h want 00000100", acc_pc[0]);
      end
    end
  endtask

  task automatic test_collide();
    int k = 0;
    lat_min = 3; lat_max = 3; rdy_pct = 100; mrdy_pct = 100;
    repeat (6) step(1'b0, 32'h0);
    arm_collide = 1'b1;
    collided    = 1'b0;
    while (!collided && k < 30) begin
      step(1'b0, 32'h0000_2000);
      k++;
    end
    arm_collide = 1'b0;
    tests_run++;
    if (!collided) begin
      tests_failed++;
      $display("FAIL collide_timeout: got no rsp+req cycle within %0d cycles, want one", k);
    end
    acc_pc.delete(); acc_instr.delete();
    run_until_acc(1, 30, "collide");
    if (collided && acc_pc.size() >= 1) begin
      tests_run++;
      if (acc_pc[0] !== 32'h0000_2000) begin
        tests_failed++;
        $display("FAIL collide_target: got %h want 00002000", acc_pc[0]);
      end
    end
  endtask

  task automatic test_wrap();
    lat_min = 1; lat_max = 1; rdy_pct = 100; mrdy_pct = 100;
    step(1'b1, 32'hFFFF_FFFB);
    acc_pc.delete(); acc_instr.delete();
    run_until_acc(3, 40, "wrap");
    if (acc_pc.size() >= 3) begin
      tests_run += 3;
      if (acc_pc[0] !== 32'hFFFF_FFF8) begin tests_failed++; $display("FAIL wrap_pc0: got %h want fffffff8", acc_pc[0]); end
      if (acc_pc[1] !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_pc1: got %h want fffffffc", acc_pc[1]); end
      if (acc_pc[2] !== 32'h0000_0000) begin tests_failed++; $display("FAIL wrap_pc2: got %h want 00000000", acc_pc[2]); end
    end
  endtask

  task automatic test_back_to_back();
    lat_min = 2; lat_max = 2; rdy_pct = 100; mrdy_pct = 100;
    repeat (5) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0400);
    step(1'b1, 32'h0000_0800);
    acc_pc.delete(); acc_instr.delete();
    run_until_acc(1, 30, "b2b");
    if (acc_pc.size() >= 1) begin
      tests_run++;
      if (acc_pc[0] !== 32'h0000_0800) begin
        tests_failed++;
        $display("FAIL b2b_target: got %h want 00000800", acc_pc[0]);
      end
    end
  endtask

  task automatic test_reset_full();
    lat_min = 1; lat_max = 1; rdy_pct = 0; mrdy_pct = 100;
    repeat (12) step(1'b0, 32'h0);
    tests_run += 2;
    if (bus.instr_valid !== 1'b1)    begin tests_failed++; $display("FAIL full_instr_valid: got %b want 1", bus.instr_valid); end
    if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL full_req_valid: got %b want 0", bus.imem_req_valid); end
    @(posedge clk);
    cyc++;
    #1;
    rst                = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.instr_ready    = 1'b0;
    clear_model();
    @(posedge clk);
    cyc++;
    #1;
    tests_run += 3;
    if (bus.instr_valid !== 1'b0)    begin tests_failed++; $display("FAIL rst_mid_instr_valid: got %b want 0", bus.instr_valid); end
    if (bus.imem_req_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_req_valid: got %b want 0", bus.imem_req_valid); end
    if (bus.instruction !== 32'h0)   begin tests_failed++; $display("FAIL rst_mid_instruction: got %h want 0", bus.instruction); end
    rst = 1'b0;
    rdy_pct = 100;
    acc_pc.delete(); acc_instr.delete();
    run_until_acc(1, 30, "rst_mid");
    if (acc_pc.size() >= 1) begin
      tests_run++;
      if (acc_pc[0] !== 32'h0) begin
        tests_failed++;
        $display("FAIL rst_mid_first_pc: got %h want 00000000", acc_pc[0]);
      end
    end
  endtask

  task automatic test_random();
    int n0;
    lat_min = 1; lat_max = 4; rdy_pct = 60; mrdy_pct = 70;
    n0 = acc_pc.size();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) < 3) step(1'b1, $urandom);
      else                        step(1'b0, 32'h0);
    end
    tests_run++;
    if (acc_pc.size() - n0 < 100) begin
      tests_failed++;
      $display("FAIL random_progress: got %0d instructions want >= 100", acc_pc.size() - n0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_collide();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_full();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
